// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM states, per-bit sample points, default tick divider.
package uart_rx_fifo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    localparam logic [3:0] SAMPLE_FIRST = 4'd7;
    localparam logic [3:0] SAMPLE_MID   = 4'd8;
    localparam logic [3:0] SAMPLE_LAST  = 4'd9;

    localparam int DEFAULT_CLKS_PER_TICK = 52;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous show-ahead FIFO; pointers carry one extra wrap bit so full/empty come from the MSB compare.
module uart_byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             overrun
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_rd;
    logic             do_wr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a write into a full FIFO is still accepted.
    assign do_wr = wr_en && (!full || do_rd);
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= wr_en && full && !rd_en;
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 16x-oversampling UART receiver (8N1) feeding a show-ahead byte FIFO.
// Define UART_RX_PARITY_EN to expect an even-parity bit between data bit 7 and the stop bit.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int CLKS_PER_TICK = DEFAULT_CLKS_PER_TICK,
    parameter int OVERSAMPLE    = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_enable,
    input  logic       rx_in,
    input  logic       rd_en,
    output logic [7:0] rx_data,
    output logic       rx_empty,
    output logic       rx_full,
    output logic       frame_err,
    output logic       overrun
);
    localparam int            CW        = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_TICK - 1);
    localparam logic [3:0]    TICK_LAST = 4'(OVERSAMPLE - 1);

    rx_state_t     state;
    logic [1:0]    sync;
    logic          rx_sync;
    logic          rx_prev;
    logic [CW-1:0] clk_cnt;
    logic [3:0]    tick_cnt;
    logic [2:0]    bit_cnt;
    logic [1:0]    samp;
    logic [7:0]    shift;
    logic          tick;
    logic          bit_val;
    logic          stop_point;
    logic          parity_ok;
    logic          push;

    assign rx_sync    = sync[1];
    assign tick       = (state != ST_IDLE) && (clk_cnt == CLK_LAST);
    assign bit_val    = majority3(samp[1], samp[0], rx_sync);
    assign stop_point = rx_enable && (state == ST_STOP) && tick && (tick_cnt == SAMPLE_LAST);

`ifdef UART_RX_PARITY_EN
    logic parity_bit;
    assign parity_ok = (parity_bit == ^shift);
`else
    assign parity_ok = 1'b1;
`endif

    assign push = stop_point && bit_val && parity_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            sync      <= 2'b11;
            rx_prev   <= 1'b1;
            clk_cnt   <= '0;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            samp      <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            sync      <= {sync[0], rx_in};
            rx_prev   <= rx_sync;
            frame_err <= 1'b0;
            if (!rx_enable) begin
                state    <= ST_IDLE;
                clk_cnt  <= '0;
                tick_cnt <= '0;
                bit_cnt  <= '0;
            end else begin
                if (state != ST_IDLE) clk_cnt <= tick ? '0 : clk_cnt + 1'b1;
                if (tick) begin
                    tick_cnt <= tick_cnt + 1'b1;
                    if (tick_cnt == SAMPLE_FIRST) samp[1] <= rx_sync;
                    if (tick_cnt == SAMPLE_MID)   samp[0] <= rx_sync;
                end
                case (state)
                    ST_IDLE: begin
                        clk_cnt  <= '0;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        if (rx_prev && !rx_sync) state <= ST_START;
                    end
                    // Glitch check at mid start bit; the bit frame then runs to its end so later samples land mid-bit.
                    ST_START: begin
                        if (tick) begin
                            if ((tick_cnt == SAMPLE_FIRST) && rx_sync) begin
                                state <= ST_IDLE;
                            end else if (tick_cnt == TICK_LAST) begin
                                tick_cnt <= '0;
                                state    <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (tick) begin
                            if (tick_cnt == SAMPLE_LAST) shift <= {bit_val, shift[7:1]};
                            if (tick_cnt == TICK_LAST) begin
                                tick_cnt <= '0;
                                bit_cnt  <= bit_cnt + 1'b1;
                                if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                    state <= ST_PARITY;
`else
                                    state <= ST_STOP;
`endif
                                end
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    ST_PARITY: begin
                        if (tick) begin
                            if (tick_cnt == SAMPLE_LAST) parity_bit <= bit_val;
                            if (tick_cnt == TICK_LAST) begin
                                tick_cnt <= '0;
                                state    <= ST_STOP;
                            end
                        end
                    end
`endif
                    ST_STOP: begin
                        if (stop_point) begin
                            if (push) begin
                                state <= ST_IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= ST_BREAK;
                            end
                        end
                    end
                    ST_BREAK: begin
                        if (rx_sync) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    uart_byte_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .rd_en   (rd_en),
        .din     (shift),
        .dout    (rx_data),
        .empty   (rx_empty),
        .full    (rx_full),
        .overrun (overrun)
    );

endmodule
